// File: rtl/case_7_pkg.sv
// Shared definitions for the shared-multiplier arbiter slice.
// Holds the parameter defaults, the output-stage state encoding and
// the round-robin picker used by the top level.
package case_7_pkg;

  localparam int unsigned DEF_NREQ       = 4;
  localparam int unsigned DEF_DIN_WIDTH  = 8;
  localparam int unsigned DEF_DOUT_WIDTH = 10;
  localparam int unsigned DEF_ID_WIDTH   = 2;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  // Widest requester vector the picker supports.
  localparam int unsigned RR_MAX   = 8;
  localparam int unsigned RR_IDX_W = $clog2(RR_MAX);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // One-hot grant on the first set bit of req, searching upward from
  // ptr+1 modulo n. Only the low n bits of req are considered.
  function automatic logic [RR_MAX-1:0] rr_pick(
    input logic [RR_MAX-1:0] req,
    input int unsigned       ptr,
    input int unsigned       n
  );
    logic [RR_MAX-1:0]   g;
    logic [RR_IDX_W-1:0] idx;
    g = '0;
    for (int unsigned k = 1; k <= RR_MAX; k++) begin
      if (k <= n) begin
        idx = RR_IDX_W'((ptr + k) % n);
        if (g == '0 && req[idx]) g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/case_7_mul_8s_8s_10_1_1.sv
// Signed multiplier core: dout = low dout_WIDTH bits of din0 * din1.
// Ports: din0, din1 signed operands; dout truncated product (no saturation).
module case_7_mul_8s_8s_10_1_1 #(
  parameter int unsigned ID         = 1,
  parameter int unsigned NUM_STAGE  = 1,
  parameter int unsigned din0_WIDTH = 8,
  parameter int unsigned din1_WIDTH = 8,
  parameter int unsigned dout_WIDTH = 10
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  localparam int unsigned PW = din0_WIDTH + din1_WIDTH;

  logic signed [PW-1:0] prod;

  // Size casts on signed operands sign-extend before the multiply.
  assign prod = PW'(signed'(din0)) * PW'(signed'(din1));
  assign dout = prod[dout_WIDTH-1:0];

endmodule

// File: rtl/case_7_mul_share_arb.sv
// Shares one signed multiplier among NREQ valid/ready requesters.
// A round-robin arbiter grants one operand pair per cycle; the product is
// returned one cycle later from a single output register tagged with the
// requester index.
// Ports:
//   ap_clk / ap_rst_n   clock, async active-low reset
//   req_vld/req_rdy     per-requester handshake (req_rdy one-hot or zero)
//   req_a/req_b         packed operands, requester i at [i*DIN_WIDTH +: DIN_WIDTH]
//   res_vld/res_rdy     result handshake
//   res_dout/res_id     truncated product and originating requester
//   op_cnt              accepted-operation counter, wraps
module case_7_mul_share_arb
  import case_7_pkg::*;
#(
  parameter int unsigned NREQ       = DEF_NREQ,
  parameter int unsigned DIN_WIDTH  = DEF_DIN_WIDTH,
  parameter int unsigned DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int unsigned ID_WIDTH   = DEF_ID_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [NREQ-1:0]           req_vld,
  output logic [NREQ-1:0]           req_rdy,
  input  logic [NREQ*DIN_WIDTH-1:0] req_a,
  input  logic [NREQ*DIN_WIDTH-1:0] req_b,
  output logic                      res_vld,
  input  logic                      res_rdy,
  output logic [DOUT_WIDTH-1:0]     res_dout,
  output logic [ID_WIDTH-1:0]       res_id,
  output logic [CNT_WIDTH-1:0]      op_cnt
);

  state_t                state, state_nxt;
  logic [ID_WIDTH-1:0]   ptr;
  logic                  stage_free;
  logic [RR_MAX-1:0]     pick;
  logic [NREQ-1:0]       grant;
  logic                  xfer;
  logic [ID_WIDTH-1:0]   gidx;
  logic [DIN_WIDTH-1:0]  a_sel, b_sel;
  logic [DOUT_WIDTH-1:0] mul_dout;

  assign res_vld    = (state == FULL);
  assign stage_free = !res_vld || res_rdy;

  always_comb begin
    pick  = rr_pick(RR_MAX'(req_vld), 32'(ptr), NREQ);
    grant = stage_free ? pick[NREQ-1:0] : '0;
  end

  assign req_rdy = grant;
  // Grant bits are only ever set on asserted req_vld lines.
  assign xfer    = |grant;

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) gidx = ID_WIDTH'(i);
    end
    a_sel = req_a[gidx*DIN_WIDTH +: DIN_WIDTH];
    b_sel = req_b[gidx*DIN_WIDTH +: DIN_WIDTH];
  end

  case_7_mul_8s_8s_10_1_1 #(
    .ID         (1),
    .NUM_STAGE  (1),
    .din0_WIDTH (DIN_WIDTH),
    .din1_WIDTH (DIN_WIDTH),
    .dout_WIDTH (DOUT_WIDTH)
  ) u_mul (
    .din0 (a_sel),
    .din1 (b_sel),
    .dout (mul_dout)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (xfer) state_nxt = FULL;
      FULL:  if (res_rdy && !xfer) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= EMPTY;
      ptr      <= ID_WIDTH'(NREQ - 1);
      res_dout <= '0;
      res_id   <= '0;
      op_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        ptr      <= gidx;
        res_dout <= mul_dout;
        res_id   <= gidx;
        op_cnt   <= op_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_case_7_mul_share_arb.sv
module tb_case_7_mul_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_vld;
  logic [3:0]  req_rdy;
  logic [31:0] req_a, req_b;
  logic        res_vld, res_rdy;
  logic [9:0]  res_dout;
  logic [1:0]  res_id;
  logic [15:0] op_cnt;

  // Second instance with a narrow counter to exercise wrap-around quickly.
  logic [3:0]  w_vld, w_rdy_o;
  logic [31:0] w_a, w_b;
  logic        w_res_vld, w_res_rdy;
  logic [9:0]  w_dout;
  logic [1:0]  w_id;
  logic [3:0]  w_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  case_7_mul_share_arb #(
    .NREQ(4), .DIN_WIDTH(8), .DOUT_WIDTH(10), .ID_WIDTH(2), .CNT_WIDTH(16)
  ) dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_dout(res_dout),
    .res_id(res_id), .op_cnt(op_cnt)
  );

  case_7_mul_share_arb #(
    .NREQ(4), .DIN_WIDTH(8), .DOUT_WIDTH(10), .ID_WIDTH(2), .CNT_WIDTH(4)
  ) dut_w (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .req_vld(w_vld), .req_rdy(w_rdy_o), .req_a(w_a), .req_b(w_b),
    .res_vld(w_res_vld), .res_rdy(w_res_rdy), .res_dout(w_dout),
    .res_id(w_id), .op_cnt(w_cnt)
  );

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] a;
    logic [31:0] b;
    logic        rr;
    logic [3:0]  e_rdy;
    logic        e_vld;
    logic [9:0]  e_dout;
    logic [1:0]  e_id;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] vld, input logic [31:0] a, input logic [31:0] b,
                              input logic rr, input logic [3:0] e_rdy, input logic e_vld,
                              input logic [9:0] e_dout, input logic [1:0] e_id,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.vld = vld; v.a = a; v.b = b; v.rr = rr; v.e_rdy = e_rdy; v.e_vld = e_vld;
    v.e_dout = e_dout; v.e_id = e_id; v.e_cnt = e_cnt;
    return v;
  endfunction

  localparam logic [31:0] RA = 32'h04030201;  // a_i = i+1
  localparam logic [31:0] RB = 32'h02020202;  // b_i = 2

  initial begin
    // Single ops and truncation corners, one per requester.
    vecs.push_back(mk(4'b0001, 32'h000000FD, 32'h00000007, 1, 4'b0001, 1, 10'h3EB, 0, 1));
    vecs.push_back(mk(4'b0010, 32'h00008000, 32'h00008000, 1, 4'b0010, 1, 10'h000, 1, 2));
    vecs.push_back(mk(4'b0100, 32'h007F0000, 32'h007F0000, 1, 4'b0100, 1, 10'h301, 2, 3));
    vecs.push_back(mk(4'b1000, 32'hFF000000, 32'h01000000, 1, 4'b1000, 1, 10'h3FF, 3, 4));
    // Drain with nothing requested: data holds.
    vecs.push_back(mk(4'b0000, 32'h0, 32'h0, 1, 4'b0000, 0, 10'h3FF, 3, 4));
    // Round robin with all requesting, no bubbles.
    vecs.push_back(mk(4'b1111, RA, RB, 1, 4'b0001, 1, 10'd2, 0, 5));
    vecs.push_back(mk(4'b1111, RA, RB, 1, 4'b0010, 1, 10'd4, 1, 6));
    vecs.push_back(mk(4'b1111, RA, RB, 1, 4'b0100, 1, 10'd6, 2, 7));
    vecs.push_back(mk(4'b1111, RA, RB, 1, 4'b1000, 1, 10'd8, 3, 8));
    vecs.push_back(mk(4'b1111, RA, RB, 1, 4'b0001, 1, 10'd2, 0, 9));
    vecs.push_back(mk(4'b1111, RA, RB, 1, 4'b0010, 1, 10'd4, 1, 10));
    // Sparse requests: search wraps past idle requesters.
    vecs.push_back(mk(4'b1001, RA, RB, 1, 4'b1000, 1, 10'd8, 3, 11));
    vecs.push_back(mk(4'b1001, RA, RB, 1, 4'b0001, 1, 10'd2, 0, 12));
    // Backpressure for three cycles, then drain plus new grant together.
    vecs.push_back(mk(4'b1111, RA, RB, 0, 4'b0000, 1, 10'd2, 0, 12));
    vecs.push_back(mk(4'b1111, RA, RB, 0, 4'b0000, 1, 10'd2, 0, 12));
    vecs.push_back(mk(4'b1111, RA, RB, 0, 4'b0000, 1, 10'd2, 0, 12));
    vecs.push_back(mk(4'b1111, RA, RB, 1, 4'b0010, 1, 10'd4, 1, 13));
    vecs.push_back(mk(4'b0000, RA, RB, 0, 4'b0000, 1, 10'd4, 1, 13));
    vecs.push_back(mk(4'b0000, RA, RB, 1, 4'b0000, 0, 10'd4, 1, 13));
    // Empty stage accepts even while res_rdy is low.
    vecs.push_back(mk(4'b0100, RA, RB, 0, 4'b0100, 1, 10'd6, 2, 14));

    rst_n = 1'b0; req_vld = '0; req_a = '0; req_b = '0; res_rdy = 1'b1;
    w_vld = '0; w_a = '0; w_b = '0; w_res_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_res_vld", 32'(res_vld), 0);
    chk("rst_res_dout", 32'(res_dout), 0);
    chk("rst_res_id", 32'(res_id), 0);
    chk("rst_op_cnt", 32'(op_cnt), 0);
    chk("rst_req_rdy", 32'(req_rdy), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      req_vld = vecs[i].vld; req_a = vecs[i].a; req_b = vecs[i].b; res_rdy = vecs[i].rr;
      #1;
      chk($sformatf("v%0d_req_rdy", i), 32'(req_rdy), 32'(vecs[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_res_vld", i), 32'(res_vld), 32'(vecs[i].e_vld));
      chk($sformatf("v%0d_res_dout", i), 32'(res_dout), 32'(vecs[i].e_dout));
      chk($sformatf("v%0d_res_id", i), 32'(res_id), 32'(vecs[i].e_id));
      chk($sformatf("v%0d_op_cnt", i), 32'(op_cnt), 32'(vecs[i].e_cnt));
    end

    // Asynchronous reset while a result is held.
    @(negedge clk);
    req_vld = '0; res_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_res_vld", 32'(res_vld), 0);
    chk("midrst_op_cnt", 32'(op_cnt), 0);
    chk("midrst_res_dout", 32'(res_dout), 0);
    @(negedge clk);
    rst_n = 1'b1; req_vld = 4'b1111; req_a = RA; req_b = RB; res_rdy = 1'b1;
    #1;
    chk("postrst_req_rdy", 32'(req_rdy), 32'b0001);
    @(posedge clk); #1;
    chk("postrst_res_id", 32'(res_id), 0);
    chk("postrst_res_dout", 32'(res_dout), 2);
    chk("postrst_op_cnt", 32'(op_cnt), 1);
    @(negedge clk);
    req_vld = '0;

    // Counter wrap on the narrow-counter instance.
    w_vld = 4'b0001; w_a = 32'h000000FD; w_b = 32'h00000007;
    repeat (15) @(posedge clk);
    #1;
    chk("wrap_cnt_max", 32'(w_cnt), 15);
    chk("wrap_dout", 32'(w_dout), 32'h3EB);
    @(posedge clk); #1;
    chk("wrap_cnt_zero", 32'(w_cnt), 0);
    @(negedge clk);
    w_vld = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
